// File: rtl/kinase_pad_sequencer.sv
// Purpose: steps a small program RAM and drives control, pump and flush pads of a kinase assay chip.
// Latency: start accepted at edge T -> busy/LOAD at T+1, first SETTLE at T+2; all outputs are registered.
// Backpressure: none; start is honoured only in IDLE and program writes are dropped while busy.
//
// Ports: clk/rst (sync, active-high); start/busy/done host handshake; cur_step = executing step index;
//        prog_we/prog_addr/prog_data program RAM write port; pad_ctrl_a, pad_pump, pad_flush_ctrl pad drives;
//        abort (only when KINASE_SEQ_ABORT_EN is defined) cuts the run short via an all-valves flush.
// Step word, MSB first: last | bank_en[PUMP_BANKS] | pump_cycles[8] | dwell[HOLD_W] | ctrl_mask[CTRL_W].
module kinase_pad_sequencer #(
    parameter int CTRL_W      = 13,
    parameter int PUMP_PHASES = 3,
    parameter int PUMP_BANKS  = 2,
    parameter int HOLD_W      = 16,
    parameter int STEP_DEPTH  = 8,
    parameter int PHASE_TICKS = 4,
    parameter int FLUSH_TICKS = 2,
    localparam int AW = $clog2(STEP_DEPTH),
    localparam int PW = 1 + PUMP_BANKS + 8 + HOLD_W + CTRL_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic [AW-1:0]                    cur_step,
    input  logic                             prog_we,
    input  logic [AW-1:0]                    prog_addr,
    input  logic [PW-1:0]                    prog_data,
    output logic [CTRL_W-1:0]                pad_ctrl_a,
    output logic [PUMP_BANKS*PUMP_PHASES-1:0] pad_pump,
    output logic [CTRL_W-1:0]                pad_flush_ctrl
`ifdef KINASE_SEQ_ABORT_EN
    ,
    input  logic                             abort
`endif
);

    localparam int TW    = $clog2(PHASE_TICKS + 1);
    localparam int PHW   = $clog2(PUMP_PHASES);
    localparam int FW    = $clog2(FLUSH_TICKS + 1);
    localparam int CNT_W = (HOLD_W > FW) ? HOLD_W : FW;

    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_TICKS - 1);
    localparam logic [TW-1:0]    TICK_LAST  = TW'(PHASE_TICKS - 1);
    localparam logic [PHW-1:0]   PHASE_LAST = PHW'(PUMP_PHASES - 1);
    localparam logic [AW-1:0]    PTR_LAST   = AW'(STEP_DEPTH - 1);

    typedef struct packed {
        logic                  last;
        logic [PUMP_BANKS-1:0] bank_en;
        logic [7:0]            pump_cycles;
        logic [HOLD_W-1:0]     dwell;
        logic [CTRL_W-1:0]     ctrl_mask;
    } step_t;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_PUMP, S_FLUSH, S_DONE
    } state_t;

    step_t ram [STEP_DEPTH];

    state_t            state_q, state_d;
    step_t             step_q, step_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;     // remaining cycles of SETTLE or FLUSH, minus one
    logic [TW-1:0]     tick_q, tick_d;   // clocks spent in the current pump phase
    logic [PHW-1:0]    phase_q, phase_d;
    logic [7:0]        cyc_q, cyc_d;     // pump rotations still to run after the current one
    logic              end_run;
    logic              flush_all;
    logic              busy_d, done_d;
    logic [CTRL_W-1:0] ctrl_d, flush_d;
    logic [PUMP_BANKS*PUMP_PHASES-1:0] pump_d;
`ifdef KINASE_SEQ_ABORT_EN
    logic              abort_q, abort_d;
`endif

    // Program RAM: synchronous write, never cleared; writes are dropped during a run.
    always_ff @(posedge clk) begin
        if (prog_we && !busy) begin
            ram[prog_addr] <= step_t'(prog_data);
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        tick_d  = tick_q;
        phase_d = phase_q;
        cyc_d   = cyc_q;
        // The RAM word is captured on the edge that leaves LOAD; outputs for the
        // first SETTLE cycle must already see it, hence the bypass.
        step_d  = (state_q == S_LOAD) ? ram[ptr_q] : step_q;
        end_run = step_q.last || (ptr_q == PTR_LAST);
`ifdef KINASE_SEQ_ABORT_EN
        abort_d = abort_q;
        end_run = end_run || abort_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    ptr_d   = '0;
                end
            end
            S_LOAD: begin
                state_d = S_SETTLE;
                cnt_d   = (step_d.dwell == '0) ? '0 : CNT_W'(step_d.dwell - 1'b1);
            end
            S_SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (step_q.pump_cycles != '0) begin
                    state_d = S_PUMP;
                    tick_d  = '0;
                    phase_d = '0;
                    cyc_d   = step_q.pump_cycles - 8'd1;
                end else begin
                    state_d = S_FLUSH;
                    cnt_d   = FLUSH_LAST;
                end
            end
            S_PUMP: begin
                // Nested tick/phase/rotation counters cover the full
                // pump_cycles*PUMP_PHASES*PHASE_TICKS span without a wide product.
                if (tick_q != TICK_LAST) begin
                    tick_d = tick_q + 1'b1;
                end else begin
                    tick_d = '0;
                    if (phase_q != PHASE_LAST) begin
                        phase_d = phase_q + 1'b1;
                    end else begin
                        phase_d = '0;
                        if (cyc_q != '0) begin
                            cyc_d = cyc_q - 8'd1;
                        end else begin
                            state_d = S_FLUSH;
                            cnt_d   = FLUSH_LAST;
                        end
                    end
                end
            end
            S_FLUSH: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (end_run) begin
                    state_d = S_DONE;
                end else begin
                    ptr_d   = ptr_q + 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`ifdef KINASE_SEQ_ABORT_EN
        // Abort re-arms nothing once an abort flush is under way, so a held
        // abort still lets the run reach DONE. DONE is already terminal.
        if (abort && !abort_q && (state_q != S_IDLE) && (state_q != S_DONE)) begin
            state_d = S_FLUSH;
            cnt_d   = FLUSH_LAST;
            abort_d = 1'b1;
        end
        if (state_d == S_DONE || state_d == S_IDLE) begin
            abort_d = 1'b0;
        end
        flush_all = abort_d;
`else
        flush_all = 1'b0;
`endif
        // Output values for the state being entered; registered below.
        busy_d  = (state_d == S_LOAD) || (state_d == S_SETTLE) ||
                  (state_d == S_PUMP) || (state_d == S_FLUSH);
        done_d  = (state_d == S_DONE);
        ctrl_d  = (state_d == S_SETTLE || state_d == S_PUMP || state_d == S_FLUSH) ?
                  step_d.ctrl_mask : '0;
        flush_d = (state_d != S_FLUSH) ? '0 : (flush_all ? '1 : step_d.ctrl_mask);
        pump_d  = '1;
        if (state_d == S_PUMP) begin
            for (int b = 0; b < PUMP_BANKS; b++) begin
                for (int k = 0; k < PUMP_PHASES; k++) begin
                    if (step_d.bank_en[b] && (phase_d == PHW'(k))) begin
                        pump_d[b*PUMP_PHASES + k] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            step_q         <= '0;
            ptr_q          <= '0;
            cnt_q          <= '0;
            tick_q         <= '0;
            phase_q        <= '0;
            cyc_q          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pad_ctrl_a     <= '0;
            pad_flush_ctrl <= '0;
            pad_pump       <= '1;
`ifdef KINASE_SEQ_ABORT_EN
            abort_q        <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            step_q         <= step_d;
            ptr_q          <= ptr_d;
            cnt_q          <= cnt_d;
            tick_q         <= tick_d;
            phase_q        <= phase_d;
            cyc_q          <= cyc_d;
            busy           <= busy_d;
            done           <= done_d;
            pad_ctrl_a     <= ctrl_d;
            pad_flush_ctrl <= flush_d;
            pad_pump       <= pump_d;
`ifdef KINASE_SEQ_ABORT_EN
            abort_q        <= abort_d;
`endif
        end
    end

    assign cur_step = ptr_q;

endmodule

// File: tb/tb_kinase_pad_sequencer.sv
// Purpose: self-checking bench for kinase_pad_sequencer with default parameters.
// Latency: per-cycle expected pad trace is queued at start and popped every cycle of the run.
// Backpressure: n/a; mid-run write/start/reset/abort are injected at chosen trace cycles.
module tb_kinase_pad_sequencer;

    localparam int PW = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [2:0]  cur_step;
    logic        prog_we;
    logic [2:0]  prog_addr;
    logic [PW-1:0] prog_data;
    logic [12:0] pad_ctrl_a;
    logic [5:0]  pad_pump;
    logic [12:0] pad_flush_ctrl;
`ifdef KINASE_SEQ_ABORT_EN
    logic        abort = 1'b0;
`endif

    always #5 clk = ~clk;

    kinase_pad_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .cur_step       (cur_step),
        .prog_we        (prog_we),
        .prog_addr      (prog_addr),
        .prog_data      (prog_data),
        .pad_ctrl_a     (pad_ctrl_a),
        .pad_pump       (pad_pump),
        .pad_flush_ctrl (pad_flush_ctrl)
`ifdef KINASE_SEQ_ABORT_EN
        ,
        .abort          (abort)
`endif
    );

    typedef struct packed {
        logic        busy;
        logic        done;
        logic [2:0]  cur;
        logic [12:0] ctrl;
        logic [12:0] flush;
        logic [5:0]  pump;
    } obs_t;

    typedef struct {
        logic        last;
        logic [1:0]  be;
        logic [7:0]  pc;
        logic [15:0] dw;
        logic [12:0] mask;
        int          exp_done;   // cycles from the start edge to the done pulse
    } vec_t;

    obs_t          q[$];
    logic [PW-1:0] tb_prog [8];
    vec_t          tbl [5];
    int            n_vec = 0;
    int            n_bad = 0;
    int            abort_idx;

    function automatic obs_t mk(input logic b, input logic d, input int cur,
                                input logic [12:0] ctrl, input logic [12:0] flush,
                                input logic [5:0] pump);
        obs_t r;
        r.busy = b; r.done = d; r.cur = 3'(cur);
        r.ctrl = ctrl; r.flush = flush; r.pump = pump;
        return r;
    endfunction

    function automatic obs_t observe();
        return mk(busy, done, int'(cur_step), pad_ctrl_a, pad_flush_ctrl, pad_pump);
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("busy=%0b done=%0b cur=%0d ctrl=%h flush=%h pump=%b",
                         o.busy, o.done, o.cur, o.ctrl, o.flush, o.pump);
    endfunction

    function automatic logic [PW-1:0] mkw(input logic last, input logic [1:0] be,
                                          input logic [7:0] pc, input logic [15:0] dw,
                                          input logic [12:0] mask);
        return {last, be, pc, dw, mask};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input obs_t got, input obs_t exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %s, want %s", name, fmt(got), fmt(exp));
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    task automatic wr(input int a, input logic [PW-1:0] d);
        prog_we = 1'b1; prog_addr = 3'(a); prog_data = d;
        tb_prog[a] = d;
        tick();
        prog_we = 1'b0;
    endtask

    // Expected cycle-by-cycle pads from LOAD of step 0 through the DONE cycle.
    task automatic build_trace(input int abort_step, output int ab_idx);
        logic        last;
        logic [1:0]  be;
        logic [7:0]  pc;
        logic [15:0] dw;
        logic [12:0] mask;
        logic [5:0]  p;
        int          nset;
        int          ph;
        ab_idx = -1;
        q.delete();
        for (int s = 0; s < 8; s++) begin
            {last, be, pc, dw, mask} = tb_prog[s];
            q.push_back(mk(1, 0, s, '0, '0, 6'h3F));
            nset = (dw == 0) ? 1 : int'(dw);
            for (int i = 0; i < nset; i++) begin
                q.push_back(mk(1, 0, s, mask, '0, 6'h3F));
                if (s == abort_step && i == 0) begin
                    ab_idx = q.size() - 1;
                    for (int j = 0; j < 2; j++) q.push_back(mk(1, 0, s, mask, 13'h1FFF, 6'h3F));
                    q.push_back(mk(0, 1, s, '0, '0, 6'h3F));
                    return;
                end
            end
            for (int i = 0; i < int'(pc) * 12; i++) begin
                ph = (i / 4) % 3;
                p  = 6'h3F;
                for (int b = 0; b < 2; b++) if (be[b]) p[b*3 + ph] = 1'b0;
                q.push_back(mk(1, 0, s, mask, '0, p));
            end
            for (int j = 0; j < 2; j++) q.push_back(mk(1, 0, s, mask, mask, 6'h3F));
            if (last || s == 7) begin
                q.push_back(mk(0, 1, s, '0, '0, 6'h3F));
                break;
            end
        end
    endtask

    // Start a run and compare every cycle against the queued trace; optional
    // one-cycle injections are applied while trace entry k is on the pads.
    task automatic run(input string tag, input int exp_done, input int we_at,
                       input int start_at, input int abort_at, input int rst_at);
        obs_t e;
        int   k;
        int   done_at;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        done_at = -1;
        while (q.size() > 0) begin
            e = q.pop_front();
            check({tag, "_trace"}, observe(), e);
            if (done && done_at < 0) done_at = k + 1;
            if (k == rst_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check({tag, "_reset"}, observe(), mk(0, 0, 0, '0, '0, 6'h3F));
                q.delete();
            end else begin
                if (k == we_at) begin
                    prog_we = 1'b1; prog_addr = 3'd0; prog_data = {PW{1'b1}};
                end
                if (k == start_at) start = 1'b1;
`ifdef KINASE_SEQ_ABORT_EN
                if (k == abort_at) abort = 1'b1;
`endif
                tick();
                prog_we = 1'b0;
                start   = 1'b0;
`ifdef KINASE_SEQ_ABORT_EN
                abort   = 1'b0;
`endif
                k++;
            end
        end
        if (rst_at < 0) begin
            if (exp_done > 0) check_int({tag, "_done_latency"}, done_at, exp_done);
            check_int({tag, "_idle_after_done"}, int'({busy, done}), 0);
        end
        if (abort_at < 0) k = k + 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        for (int i = 0; i < 8; i++) tb_prog[i] = '0;
        tick();
        tick();
        check("reset", observe(), mk(0, 0, 0, '0, '0, 6'h3F));
        rst = 1'b0;
        tick();

        tbl[0] = '{1'b1, 2'b01, 8'd2, 16'd3, 13'h0A5, 31};
        tbl[1] = '{1'b1, 2'b00, 8'd0, 16'd0, 13'h1FFF, 5};
        tbl[2] = '{1'b1, 2'b11, 8'd1, 16'd1, 13'h123, 17};
        tbl[3] = '{1'b1, 2'b10, 8'd3, 16'd5, 13'h001, 45};
        tbl[4] = '{1'b1, 2'b11, 8'd0, 16'd2, 13'h800, 6};

        for (int v = 0; v < 5; v++) begin
            wr(0, mkw(tbl[v].last, tbl[v].be, tbl[v].pc, tbl[v].dw, tbl[v].mask));
            build_trace(-1, abort_idx);
            run($sformatf("vec%0d", v), tbl[v].exp_done, -1, -1, -1, -1);
        end

        // Eight minimal steps, none marked last: stops after step 7, 4 cycles each.
        for (int i = 0; i < 8; i++) wr(i, mkw(1'b0, 2'b00, 8'd0, 16'd0, 13'(i * 3 + 1)));
        build_trace(-1, abort_idx);
        run("eight_steps", 33, -1, -1, -1, -1);

        // Mid-run program write and start are both ignored; rerun rereads step 0.
        wr(0, mkw(tbl[0].last, tbl[0].be, tbl[0].pc, tbl[0].dw, tbl[0].mask));
        build_trace(-1, abort_idx);
        run("busy_guard", 31, 10, 12, -1, -1);
        build_trace(-1, abort_idx);
        run("reread", 31, -1, -1, -1, -1);

        // Reset while pumping, then a fresh run from step 0.
        build_trace(-1, abort_idx);
        run("rst_mid_pump", -1, -1, -1, -1, 6);
        build_trace(-1, abort_idx);
        run("rerun", 31, -1, -1, -1, -1);

`ifdef KINASE_SEQ_ABORT_EN
        wr(0, mkw(1'b0, 2'b11, 8'd1, 16'd0, 13'h011));
        wr(1, mkw(1'b1, 2'b01, 8'd2, 16'd4, 13'h0F0));
        build_trace(1, abort_idx);
        run("abort", -1, -1, -1, abort_idx, -1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
